mq_scheduler: RTL
=================

# mq_scheduler

Synthesizable controller for 16 logical circular queues sharing one external simple dual-port RAM. It owns all per-queue write/read pointers, accepts pushes addressed to a queue index, and drains non-empty, enabled queues through a round-robin scheduler onto a single valid/ready output stream. It replaces the behavioural 16-queue bench model in hardware and sits between the producers and the single consumer of the shared buffer.

## Interface
- WIDTH, 32, data word width
- DEPTH_LOG2, 10, log2 of entries per queue; usable capacity 2^DEPTH_LOG2 - 1
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  push request
- push_idx  in  4  target queue
- push_data  in  WIDTH  word to enqueue
- push_ready  out  1  combinational: !full[push_idx] && !(flush_valid && flush_idx==push_idx)
- flush_valid  in  1  discard contents of queue flush_idx
- flush_idx  in  4  queue to flush
- pop_mask  in  16  per-queue scheduling enable
- pop_valid  out  1  output word valid
- pop_idx  out  4  source queue of pop_data
- pop_data  out  WIDTH  dequeued word
- pop_ready  in  1  consumer accept
- mem_we  out  1  RAM write strobe
- mem_waddr  out  4+DEPTH_LOG2  {push_idx, wr_ptr[push_idx]}
- mem_wdata  out  WIDTH  push_data
- mem_re  out  1  RAM read strobe
- mem_raddr  out  4+DEPTH_LOG2  {grant_idx, rd_ptr[grant_idx]}
- mem_rdata  in  WIDTH  RAM read data, registered, valid the cycle after mem_re
- empty  out  16  empty[i] = (wr_ptr[i] == rd_ptr[i])
- full  out  16  full[i] = (wr_ptr[i] + 1 == rd_ptr[i]) modulo 2^DEPTH_LOG2

## Operation
- Pointers: 16 wr_ptr and 16 rd_ptr registers, DEPTH_LOG2 bits each; increment wraps naturally mod 2^DEPTH_LOG2.
- Push: handshake = push_valid && push_ready. Same cycle: mem_we=1 (combinational), waddr/wdata as above; wr_ptr[push_idx] += 1 at edge. Push to full queue stalls (push_ready=0); nothing written, no error.
- Flush: flush_valid sets rd_ptr[flush_idx] <= wr_ptr[flush_idx] at edge. Flush beats a same-cycle push to the same queue (push stalled) and removes that queue from the same-cycle grant. A word already read (state RD/VALID) is still delivered.
- Scheduler FSM, three states:
  - IDLE: eligible[i] = !empty[i] && pop_mask[i] && !(flush_valid && flush_idx==i). If any eligible: grant first eligible index searching upward from rr_ptr with wrap; mem_re=1, mem_raddr as above; rd_ptr[grant] += 1; latch grant into pop_idx; rr_ptr <= grant+1 mod 16; -> RD. Else stay.
  - RD: mem_rdata valid; pop_data <= mem_rdata; pop_valid <= 1; -> VALID.
  - VALID: hold pop_valid/pop_idx/pop_data stable; on pop_ready, pop_valid <= 0; -> IDLE.
- Push and pop on the same queue in the same cycle are independent (separate pointers). RAM write committed in cycle N is visible to a read issued in N+1; the FSM cannot read a slot in the cycle it is written because empty derives from registered pointers.
- Reset: all pointers 0, rr_ptr 0, state IDLE, pop_valid 0, pop_idx 0, pop_data 0; mem_we/mem_re follow their equations (0 unless push handshake / IDLE grant). After reset empty=16'hFFFF, full=0. Reset mid-transfer discards the in-flight word and all queue contents.

## Timing
- Push accepted cycle 0 -> empty bit clears cycle 1 -> grant/mem_re cycle 1 -> pop_valid high cycle 3 (pop_mask bit set, FSM idle).
- Pop throughput: one word per 3 cycles with pop_ready held high; each extra low pop_ready cycle adds one.
- push_ready, mem_we, mem_re, mem_raddr/waddr are combinational from registers and inputs; pop_* are registered.

## Test plan
- Reset, push 0xA5A5_0001 to queue 3, pop_mask=16'hFFFF, pop_ready=1 -> pop_valid at cycle 3 with pop_idx=3, pop_data=0xA5A5_0001; empty returns to 16'hFFFF.
- Push one word each to queues 0, 5, 15, pop_mask=16'hFFFF -> output order idx 0, 5, 15; then push queues 0 and 15 again with rr_ptr=0 after wrap -> order 0, 15.
- DEPTH_LOG2=2: push 3 words to queue 7 -> full[7]=1, 4th push sees push_ready=0 and mem_we=0; drain gives 3 words in order; pointers wrap correctly over 10 fill/drain cycles.
- pop_mask=16'h0002 with queues 0 and 1 non-empty -> only queue 1 drained; queue 0 stays non-empty until its mask bit is set.
- Push to queue 4 and flush_valid/flush_idx=4 same cycle -> push_ready=0, empty[4]=1 next cycle, no grant of queue 4.
- Hold pop_ready=0 for 5 cycles in VALID -> pop_data/pop_idx stable, no mem_re; assert rst mid-VALID -> pop_valid=0 next cycle, all empty.

Source files
------------

// File: rtl/mq_scheduler.sv
// Sixteen circular queues sharing one external simple dual-port RAM, with
// per-queue pointers and a round-robin drain onto a single valid/ready stream.
//
// state   | meaning
// S_IDLE  | looking for an eligible queue; a grant issues the RAM read
// S_RD    | registered RAM data arrives and is captured into pop_data
// S_VALID | word presented on pop_*; held until the consumer accepts
module mq_scheduler #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    input  logic [3:0]              push_idx,
    input  logic [WIDTH-1:0]        push_data,
    output logic                    push_ready,
    input  logic                    flush_valid,
    input  logic [3:0]              flush_idx,
    input  logic [15:0]             pop_mask,
    output logic                    pop_valid,
    output logic [3:0]              pop_idx,
    output logic [WIDTH-1:0]        pop_data,
    input  logic                    pop_ready,
    output logic                    mem_we,
    output logic [4+DEPTH_LOG2-1:0] mem_waddr,
    output logic [WIDTH-1:0]        mem_wdata,
    output logic                    mem_re,
    output logic [4+DEPTH_LOG2-1:0] mem_raddr,
    input  logic [WIDTH-1:0]        mem_rdata,
    output logic [15:0]             empty,
    output logic [15:0]             full
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_VALID} state_t;

    state_t                state, state_next;
    logic [DEPTH_LOG2-1:0] wr_ptr [16];
    logic [DEPTH_LOG2-1:0] rd_ptr [16];
    logic [3:0]            rr_ptr;
    logic [15:0]           flush_mask;
    logic [15:0]           eligible;
    logic                  grant_found;
    logic [3:0]            grant_idx;
    logic [3:0]            cand;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = ((wr_ptr[i] + PTR_ONE) == rd_ptr[i]);
        end
    end

    // A flush wins over a same-cycle push or grant on the same queue.
    assign flush_mask = flush_valid ? (16'h0001 << flush_idx) : 16'h0000;
    assign eligible   = ~empty & pop_mask & ~flush_mask;

    assign push_ready = !full[push_idx] && !(flush_valid && (flush_idx == push_idx));
    assign mem_we     = push_valid && push_ready;
    assign mem_waddr  = {push_idx, wr_ptr[push_idx]};
    assign mem_wdata  = push_data;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = '0;
        for (int k = 0; k < 16; k++) begin
            cand = rr_ptr + k[3:0];
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_found) state_next = S_RD;
            S_RD:    state_next = S_VALID;
            S_VALID: if (pop_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re    = (state == S_IDLE) && grant_found;
        mem_raddr = {grant_idx, rd_ptr[grant_idx]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            if (mem_we) wr_ptr[push_idx] <= wr_ptr[push_idx] + PTR_ONE;
            if (flush_valid) rd_ptr[flush_idx] <= wr_ptr[flush_idx];
            if (mem_re) begin
                rd_ptr[grant_idx] <= rd_ptr[grant_idx] + PTR_ONE;
                rr_ptr            <= grant_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid <= 1'b0;
            pop_idx   <= '0;
            pop_data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (mem_re) pop_idx <= grant_idx;
                S_RD: begin
                    pop_data  <= mem_rdata;
                    pop_valid <= 1'b1;
                end
                S_VALID: if (pop_ready) pop_valid <= 1'b0;
                default: pop_valid <= 1'b0;
            endcase
        end
    end

endmodule
